lc3b_eviction_drain: RTL

- Write-back eviction buffer between the L2 cache and physical memory.
- L2 pushes evicted dirty lines; the block queues them and drains them to pmem one at a time.
- While a line is queued, it answers L2 read-miss lookups, so L2 never fetches stale data from pmem.
- Acts as the reader/drain side of the eviction entry that L2 writes.

---
 rtl/lc3b_eviction_drain_pkg.sv | 25 ++
 rtl/lc3b_evb_match.sv | 34 +++
 rtl/lc3b_eviction_drain.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/lc3b_eviction_drain_pkg.sv
// Shared types for the L2 write-back eviction drain buffer: line address,
// FSM state and the eviction entry layout.
package lc3b_eviction_drain_pkg;

  typedef logic [11:0]  lc3b_line_addr;
  typedef logic [127:0] lc3b_line_data;

  typedef enum logic {
    evb_idle  = 1'b0,
    evb_write = 1'b1
  } lc3b_evb_state;

  typedef struct packed {
    logic          valid;
    logic          dirty;
    lc3b_line_addr addr;
    lc3b_line_data data;
  } lc3b_eviction_array_entry;

  // Line-aligned byte address of a stored line; the offset nibble is always zero.
  function automatic logic [15:0] lc3b_line_base(input lc3b_line_addr a);
    return {a, 4'h0};
  endfunction

endpackage

// File: rtl/lc3b_evb_match.sv
// DEPTH-way line-address compare that reports the youngest matching valid
// entry, where age is measured backwards from the FIFO tail.
module lc3b_evb_match
  import lc3b_eviction_drain_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          [DEPTH-1:0] entry_valid,
  input  lc3b_line_addr                 [DEPTH-1:0] entry_addr,
  input  logic        [$clog2(DEPTH)-1:0]           tail,
  input  lc3b_line_addr                             query,
  output logic                                      hit,
  output logic        [$clog2(DEPTH)-1:0]           sel
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Walk from oldest slot (tail-DEPTH) to youngest (tail-1); the last match wins.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail - PTR_W'(k);
      if (entry_valid[idx] && (entry_addr[idx] == query)) begin
        hit = 1'b1;
        sel = idx;
      end
    end
  end

endmodule

// File: rtl/lc3b_eviction_drain.sv
// Write-back eviction buffer between L2 and pmem: queues dirty lines, drains
// them in order, and forwards queued data to L2 lookups. Optional in-place
// merge of repeated evictions is enabled by LC3B_EVICTION_MERGE_EN.
module lc3b_eviction_drain
  import lc3b_eviction_drain_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         evict_valid,
  input  logic [15:0]  evict_addr,
  input  logic [127:0] evict_data,
  output logic         evict_ready,
  input  logic [15:0]  lookup_addr,
  output logic         lookup_hit,
  output logic [127:0] lookup_data,
  input  logic         drain_allow,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic         pmem_resp,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  lc3b_eviction_array_entry entries_q [DEPTH];
  lc3b_eviction_array_entry entries_d [DEPTH];
  logic [PTR_W-1:0]         head_q, head_d;
  logic [PTR_W-1:0]         tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;
  lc3b_evb_state            state_q, state_d;
  logic                     pmem_write_q, pmem_write_d;
  logic [15:0]              pmem_address_q, pmem_address_d;
  logic [127:0]             pmem_wdata_q, pmem_wdata_d;

  logic [DEPTH-1:0]                valid_vec;
  lc3b_line_addr [DEPTH-1:0]       addr_vec;
  logic                            lk_hit;
  logic [PTR_W-1:0]                lk_idx;
  logic                            merge_hit;
  logic [PTR_W-1:0]                merge_idx;
  logic                            push, pop, do_merge, do_alloc;
  logic                            unused_low_bits;

  assign unused_low_bits = ^{evict_addr[3:0], lookup_addr[3:0]};

  always_comb begin
    valid_vec = '0;
    addr_vec  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entries_q[i].valid;
      addr_vec[i]  = entries_q[i].addr;
    end
  end

  lc3b_evb_match #(.DEPTH(DEPTH)) u_lookup_match (
    .entry_valid (valid_vec),
    .entry_addr  (addr_vec),
    .tail        (tail_q),
    .query       (lookup_addr[15:4]),
    .hit         (lk_hit),
    .sel         (lk_idx)
  );

`ifdef LC3B_EVICTION_MERGE_EN
  logic [DEPTH-1:0] merge_valid_vec;

  // The in-flight head is invisible to merging so its pmem data never changes.
  always_comb begin
    merge_valid_vec = valid_vec;
    if (state_q == evb_write) merge_valid_vec[head_q] = 1'b0;
  end

  lc3b_evb_match #(.DEPTH(DEPTH)) u_merge_match (
    .entry_valid (merge_valid_vec),
    .entry_addr  (addr_vec),
    .tail        (tail_q),
    .query       (evict_addr[15:4]),
    .hit         (merge_hit),
    .sel         (merge_idx)
  );
`else
  assign merge_hit = 1'b0;
  assign merge_idx = '0;
`endif

  assign evict_ready  = (count_q < CNT_W'(DEPTH)) || merge_hit;
  assign empty        = (count_q == '0);
  assign lookup_hit   = lk_hit;
  assign lookup_data  = lk_hit ? entries_q[lk_idx].data : '0;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

  assign push     = evict_valid && evict_ready;
  assign pop      = (state_q == evb_write) && pmem_resp;
  assign do_merge = push && merge_hit;
  assign do_alloc = push && !merge_hit;

  always_comb begin
    entries_d      = entries_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    state_d        = state_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;

    if (pop) begin
      entries_d[head_q].valid = 1'b0;
      entries_d[head_q].dirty = 1'b0;
      head_d                  = head_q + PTR_W'(1);
    end

    if (do_merge) entries_d[merge_idx].data = evict_data;

    if (do_alloc) begin
      entries_d[tail_q].valid = 1'b1;
      entries_d[tail_q].dirty = 1'b1;
      entries_d[tail_q].addr  = evict_addr[15:4];
      entries_d[tail_q].data  = evict_data;
      tail_d                  = tail_q + PTR_W'(1);
    end

    case ({do_alloc, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      evb_idle: begin
        if ((count_q != '0) && drain_allow) begin
          state_d        = evb_write;
          pmem_write_d   = 1'b1;
          pmem_address_d = lc3b_line_base(entries_q[head_q].addr);
          // A merge landing on the head this same cycle must reach pmem.
          pmem_wdata_d   = (do_merge && (merge_idx == head_q)) ? evict_data
                                                               : entries_q[head_q].data;
        end
      end
      evb_write: begin
        if (pmem_resp) begin
          state_d      = evb_idle;
          pmem_write_d = 1'b0;
        end
      end
      default: begin
        state_d      = evb_idle;
        pmem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      state_q        <= evb_idle;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      state_q        <= state_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

endmodule
